// File: rtl/dp_mem_pipe.sv
// Simple dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable same-address collision behaviour, post-reset zero sweep and
// out-of-range access flagging.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | zero sweep running, one word per cycle; busy=1, requests dropped
// ST_READY | normal read/write operation; left only through reset
module dp_mem_pipe #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int RD_LAT      = 1,
  parameter int COLL_MODE   = 0,
  parameter int INIT_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  wr,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_be,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int NB = DATA_W / 8;
  // One extra bit so the compare also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ctr, ctr_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok, rd_ok, w_in, r_in, wr_acc;
  logic [DATA_W-1:0]   w_merged, rd_word;

  assign busy   = (state == ST_INIT);
  assign wr_ok  = enb & wr & ~busy;
  assign rd_ok  = enb & rd & ~busy;
  assign w_in   = ({1'b0, w_addr} < DEPTH_L);
  assign r_in   = ({1'b0, r_addr} < DEPTH_L);
  assign wr_acc = wr_ok & w_in;

  // State and sweep counter registers; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= (INIT_ON_RST != 0) ? ST_INIT : ST_READY;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  // Next-state: sweep one word per cycle, leave INIT after the last word.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    case (state)
      ST_INIT: begin
        ctr_nxt = ctr + 1'b1;
        if (ctr == LAST_L) begin
          state_nxt = ST_READY;
          ctr_nxt   = '0;
        end
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  // Byte-merged write word: enabled bytes from w_data, the rest from memory.
  always_comb begin
    w_merged = mem[w_addr];
    for (int i = 0; i < NB; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_data[8*i +: 8];
    end
  end

  // Read word: zero for out-of-range, merged word on a write-first collision.
  always_comb begin
    rd_word = '0;
    if (r_in) begin
      rd_word = mem[r_addr];
      if (COLL_MODE == 1 && wr_acc && (w_addr == r_addr)) rd_word = w_merged;
    end
  end

  // Storage: the sweep owns the array while busy, otherwise accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (busy)        mem[ctr]    <= '0;
      else if (wr_acc) mem[w_addr] <= w_merged;
    end
  end

  // Out-of-range flag, one pulse per offending accepted request cycle.
  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else      err <= (wr_ok & ~w_in) | (rd_ok & ~r_in);
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // Two-stage read pipe; r_data only moves when a result arrives.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        r_valid  <= 1'b0;
        r_data   <= '0;
      end else begin
        s1_valid <= rd_ok;
        if (rd_ok) s1_data <= rd_word;
        r_valid  <= s1_valid;
        if (s1_valid) r_data <= s1_data;
      end
    end
  end else begin : g_lat1
    // Single-stage read pipe; r_data only moves when a result arrives.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= rd_ok;
        if (rd_ok) r_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dp_mem_pipe.sv
// Scoreboard bench for dp_mem_pipe: u_a uses defaults (DEPTH 16, RD_LAT 1,
// read-first), u_b uses DEPTH 12, RD_LAT 2, write-first.
module tb_dp_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_enb, a_wr, a_rd, a_r_valid, a_busy, a_err;
  logic [3:0]  a_w_addr, a_r_addr, a_w_be;
  logic [31:0] a_w_data, a_r_data;
  logic        b_rst, b_enb, b_wr, b_rd, b_r_valid, b_busy, b_err;
  logic [3:0]  b_w_addr, b_r_addr, b_w_be;
  logic [31:0] b_w_data, b_r_data;

  dp_mem_pipe u_a (
    .clk(clk), .rst(a_rst), .enb(a_enb), .wr(a_wr), .w_addr(a_w_addr),
    .w_data(a_w_data), .w_be(a_w_be), .rd(a_rd), .r_addr(a_r_addr),
    .r_data(a_r_data), .r_valid(a_r_valid), .busy(a_busy), .err(a_err)
  );

  dp_mem_pipe #(.DEPTH(12), .RD_LAT(2), .COLL_MODE(1)) u_b (
    .clk(clk), .rst(b_rst), .enb(b_enb), .wr(b_wr), .w_addr(b_w_addr),
    .w_data(b_w_data), .w_be(b_w_be), .rd(b_rd), .r_addr(b_r_addr),
    .r_data(b_r_data), .r_valid(b_r_valid), .busy(b_busy), .err(b_err)
  );

  typedef struct {int t; logic [31:0] d;} exp_t;
  exp_t qa[$], qb[$];
  int   ea[$], eb[$];
  int   nchk = 0, nfail = 0;
  exp_t ma, mb;
  bit   xa, xb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for u_a: read results in order and at the expected cycle, err pulses.
  always @(negedge clk) begin
    if (a_r_valid) begin
      if (qa.size() == 0) chk("a_unexpected_rvalid", 1, 0);
      else begin
        ma = qa.pop_front();
        chk("a_rdata", a_r_data, ma.d);
        chk("a_rtime", cyc, ma.t);
      end
    end
    xa = (ea.size() > 0) && (ea[0] == cyc);
    if (xa) void'(ea.pop_front());
    if (a_err || xa) chk("a_err", {31'b0, a_err}, {31'b0, xa});
  end

  // Monitor for u_b.
  always @(negedge clk) begin
    if (b_r_valid) begin
      if (qb.size() == 0) chk("b_unexpected_rvalid", 1, 0);
      else begin
        mb = qb.pop_front();
        chk("b_rdata", b_r_data, mb.d);
        chk("b_rtime", cyc, mb.t);
      end
    end
    xb = (eb.size() > 0) && (eb[0] == cyc);
    if (xb) void'(eb.pop_front());
    if (b_err || xb) chk("b_err", {31'b0, b_err}, {31'b0, xb});
  end

  task automatic da(input logic e, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic r, input logic [3:0] ra,
                    input logic xv, input logic [31:0] xd, input logic xe);
    @(negedge clk);
    a_enb = e; a_wr = w; a_w_addr = wa; a_w_data = wd; a_w_be = be; a_rd = r; a_r_addr = ra;
    if (xv) qa.push_back('{t: cyc + 1, d: xd});
    if (xe) ea.push_back(cyc + 1);
  endtask

  task automatic db(input logic e, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic r, input logic [3:0] ra,
                    input logic xv, input logic [31:0] xd, input logic xe);
    @(negedge clk);
    b_enb = e; b_wr = w; b_w_addr = wa; b_w_data = wd; b_w_be = be; b_rd = r; b_r_addr = ra;
    if (xv) qb.push_back('{t: cyc + 2, d: xd});
    if (xe) eb.push_back(cyc + 1);
  endtask

  task automatic a_write(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    da(1, 1, ad, d, be, 0, 0, 0, 0, 0);
  endtask
  task automatic a_read(input logic [3:0] ad, input logic [31:0] x);
    da(1, 0, 0, 0, 0, 1, ad, 1, x, 0);
  endtask
  task automatic b_write(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    db(1, 1, ad, d, be, 0, 0, 0, 0, 0);
  endtask
  task automatic b_read(input logic [3:0] ad, input logic [31:0] x);
    db(1, 0, 0, 0, 0, 1, ad, 1, x, 0);
  endtask

  // Release reset and count negedge samples with busy high (bounded).
  task automatic a_release(output int n);
    @(negedge clk);
    a_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!a_busy) break;
      n++;
      @(negedge clk);
    end
  endtask
  task automatic b_release(output int n);
    @(negedge clk);
    b_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!b_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    a_rst = 0; a_enb = 0; a_wr = 0; a_rd = 0; a_w_addr = 0; a_r_addr = 0; a_w_be = 0; a_w_data = 0;
    b_rst = 0; b_enb = 0; b_wr = 0; b_rd = 0; b_w_addr = 0; b_r_addr = 0; b_w_be = 0; b_w_data = 0;
    repeat (3) @(negedge clk);

    // u_a: sweep length and reset outputs, then every word reads zero
    a_release(n);
    chk("a_busy_len", n, 16);
    chk("a_rdata_rst", a_r_data, 0);
    for (int i = 0; i < 16; i++) a_read(4'(i), 32'h0);

    // byte enables, zero-enable no-op, enb=0 ignored
    a_write(3, 32'hDEADBEEF, 4'b1111);
    a_write(3, 32'h11223344, 4'b0101);
    a_read(3, 32'hDE22BE44);
    a_write(3, 32'hFFFFFFFF, 4'b0000);
    a_read(3, 32'hDE22BE44);
    da(0, 1, 4, 32'h12345678, 4'b1111, 1, 4, 0, 0, 0);
    a_read(4, 32'h0);

    // read-first collision, independent ports, write then immediate read
    a_write(5, 32'hAAAAAAAA, 4'b1111);
    da(1, 1, 5, 32'h55555555, 4'b1111, 1, 5, 1, 32'hAAAAAAAA, 0);
    a_read(5, 32'h55555555);
    da(1, 1, 6, 32'h0BADF00D, 4'b1111, 1, 3, 1, 32'hDE22BE44, 0);
    a_read(6, 32'h0BADF00D);
    a_write(7, 32'h76543210, 4'b1100);
    a_read(7, 32'h76540000);
    a_write(10, 32'hCAFEF00D, 4'b1111);
    a_read(10, 32'hCAFEF00D);

    // reset coinciding with a read, then reset again mid-sweep at ctr=7
    @(negedge clk);
    a_rst = 0; a_enb = 1; a_wr = 0; a_rd = 1; a_r_addr = 10;
    @(negedge clk);
    a_rst = 1; a_enb = 1; a_rd = 1; a_wr = 1; a_w_addr = 9; a_w_data = 32'hFFFFFFFF; a_w_be = 4'hF;
    repeat (7) @(negedge clk);
    chk("a_busy_mid", {31'b0, a_busy}, 1);
    a_rst = 0; a_enb = 0; a_rd = 0; a_wr = 0;
    @(negedge clk);
    a_release(n);
    chk("a_busy_len_restart", n, 16);
    chk("a_rdata_after_rst", a_r_data, 0);
    a_read(10, 32'h0);
    a_read(3, 32'h0);
    a_read(9, 32'h0);
    a_read(15, 32'h0);
    da(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // u_b: DEPTH 12, RD_LAT 2, write-first
    b_release(n);
    chk("b_busy_len", n, 12);
    for (int i = 0; i < 12; i++) b_read(4'(i), 32'h0);
    b_write(1, 32'h11111111, 4'b1111);
    b_write(2, 32'h22222222, 4'b1111);
    b_write(3, 32'h33333333, 4'b1111);
    b_read(1, 32'h11111111);
    b_read(2, 32'h22222222);
    b_read(3, 32'h33333333);

    b_write(5, 32'hAAAAAAAA, 4'b1111);
    db(1, 1, 5, 32'h55555555, 4'b1111, 1, 5, 1, 32'h55555555, 0);
    db(1, 1, 5, 32'h12345678, 4'b0011, 1, 5, 1, 32'h55555678, 0);
    b_read(5, 32'h55555678);

    // out-of-range accesses and the last valid word
    db(1, 1, 14, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 1);
    b_read(6, 32'h0);
    b_read(2, 32'h22222222);
    db(1, 0, 0, 0, 0, 1, 14, 1, 32'h0, 1);
    b_read(11, 32'h0);
    db(1, 1, 12, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 1);
    b_read(4, 32'h0);
    db(0, 1, 14, 32'hFFFFFFFF, 4'b1111, 1, 14, 0, 0, 0);
    b_write(11, 32'hA5A5A5A5, 4'b1111);
    b_read(11, 32'hA5A5A5A5);

    // reset with a read in the second pipe stage
    db(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    b_rst = 0; b_enb = 0; b_rd = 0; b_wr = 0;
    @(negedge clk);
    b_release(n);
    chk("b_busy_len_restart", n, 12);
    chk("b_rdata_after_rst", b_r_data, 0);
    b_read(1, 32'h0);
    b_read(11, 32'h0);
    db(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (6) @(negedge clk);
    chk("a_rq_drained", qa.size(), 0);
    chk("a_eq_drained", ea.size(), 0);
    chk("b_rq_drained", qb.size(), 0);
    chk("b_eq_drained", eb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
